// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op codes, commit-stage record and widths for the HI/LO accumulator bank
package hilo_pkg;

  localparam int OP_W        = 3;
  localparam int HILO_DATA_W = 32;
  // Commit-stage index field is sized for the largest bank; compares zero-extend into it.
  localparam int HILO_AC_W   = 8;

  typedef enum logic [OP_W-1:0] {
    OP_NOP     = 3'd0,
    OP_WR_HI   = 3'd1,
    OP_WR_LO   = 3'd2,
    OP_WR_BOTH = 3'd3,
    OP_MADD    = 3'd4,
    OP_MSUB    = 3'd5,
    OP_CLR     = 3'd6,
    OP_RSVD    = 3'd7
  } hilo_op_e;

  typedef struct packed {
    logic                     valid;
    hilo_op_e                 op;
    logic [HILO_AC_W-1:0]     ac;
    logic [2*HILO_DATA_W-1:0] operand;
  } hilo_s1_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op != OP_NOP) && (op != OP_RSVD);
  endfunction

endpackage

// File: rtl/hilo_acc_alu.sv
// rtl/hilo_acc_alu.sv - combinational next-value for one accumulator from op, old value and operand
module hilo_acc_alu
  import hilo_pkg::*;
#(
  parameter int DATA_W = HILO_DATA_W
) (
  input  logic [OP_W-1:0]     i_op,
  input  logic [2*DATA_W-1:0] i_old,
  input  logic [2*DATA_W-1:0] i_operand,
  output logic [2*DATA_W-1:0] o_nv
);

  localparam int ACC_W = 2 * DATA_W;

  logic             w_inv;
  logic [ACC_W-1:0] w_b;
  logic [ACC_W-1:0] w_sum;

  // MSUB reuses the MADD adder as old + ~operand + 1.
  assign w_inv = (i_op == OP_MSUB);
  assign w_b   = w_inv ? ~i_operand : i_operand;
  assign w_sum = i_old + w_b + {{(ACC_W-1){1'b0}}, w_inv};

  always_comb begin
    o_nv = i_old;
    case (i_op)
      OP_WR_HI:         o_nv = {i_operand[ACC_W-1:DATA_W], i_old[DATA_W-1:0]};
      OP_WR_LO:         o_nv = {i_old[ACC_W-1:DATA_W], i_operand[DATA_W-1:0]};
      OP_WR_BOTH:       o_nv = i_operand;
      OP_MADD, OP_MSUB: o_nv = w_sum;
      OP_CLR:           o_nv = '0;
      default:          o_nv = i_old;
    endcase
  end

endmodule

// File: rtl/hilo_acc_bank.sv
// rtl/hilo_acc_bank.sv - bank of HI/LO accumulators with a one-deep commit stage and read bypass
module hilo_acc_bank
  import hilo_pkg::*;
#(
  parameter int DATA_W = HILO_DATA_W,
  parameter int NUM_AC = 4,
  parameter int AC_W   = (NUM_AC > 1) ? $clog2(NUM_AC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [OP_W-1:0]   wr_op,
  input  logic [AC_W-1:0]   wr_ac,
  input  logic [DATA_W-1:0] wr_hi,
  input  logic [DATA_W-1:0] wr_lo,
  input  logic              flush,
  input  logic [AC_W-1:0]   rd_ac,
  output logic [DATA_W-1:0] rd_hi,
  output logic [DATA_W-1:0] rd_lo,
  output logic              pend
);

  localparam int ACC_W = 2 * DATA_W;

  hilo_s1_t             r_s1;
  logic [ACC_W-1:0]     r_acc [NUM_AC];

  logic                 w_wr_ac_ok;
  logic                 w_accept;
  logic                 w_commit;
  logic [ACC_W-1:0]     w_old;
  logic [ACC_W-1:0]     w_nv;
  logic [ACC_W-1:0]     w_rd_acc;
  logic [ACC_W-1:0]     w_rd_val;
  logic [HILO_AC_W-1:0] w_rd_ac_ext;

  // Indices past the last accumulator are never accepted, so S1.ac is always in range.
  always_comb begin
    w_wr_ac_ok = 1'b0;
    for (int i = 0; i < NUM_AC; i++) begin
      if (wr_ac == AC_W'(i)) w_wr_ac_ok = 1'b1;
    end
  end

  assign w_accept = wr_valid && !flush && w_wr_ac_ok && op_is_legal(wr_op);
  assign w_commit = r_s1.valid && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
    end else begin
      r_s1.valid <= w_accept;
      if (w_accept) begin
        r_s1.op      <= hilo_op_e'(wr_op);
        r_s1.ac      <= HILO_AC_W'(wr_ac);
        r_s1.operand <= {wr_hi, wr_lo};
      end
    end
  end

  always_comb begin
    w_old = '0;
    for (int i = 0; i < NUM_AC; i++) begin
      if (r_s1.ac == HILO_AC_W'(i)) w_old = r_acc[i];
    end
  end

  hilo_acc_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .i_op     (r_s1.op),
    .i_old    (w_old),
    .i_operand(r_s1.operand),
    .o_nv     (w_nv)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_AC; i++) r_acc[i] <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_AC; i++) begin
        if (r_s1.ac == HILO_AC_W'(i)) r_acc[i] <= w_nv;
      end
    end
  end

  // An op sitting in S1 is already architecturally visible to EX through the bypass.
  assign w_rd_ac_ext = HILO_AC_W'(rd_ac);

  always_comb begin
    w_rd_acc = '0;
    for (int i = 0; i < NUM_AC; i++) begin
      if (rd_ac == AC_W'(i)) w_rd_acc = r_acc[i];
    end
    w_rd_val = (r_s1.valid && (r_s1.ac == w_rd_ac_ext)) ? w_nv : w_rd_acc;
  end

  assign {rd_hi, rd_lo} = w_rd_val;
  assign pend           = r_s1.valid;

endmodule

// File: tb/tb_hilo_acc_bank.sv
// tb/tb_hilo_acc_bank.sv - checks three bank sizes (4, 3, 1) sharing one stimulus stream against a model
module tb_hilo_acc_bank;

  localparam int NI = 3;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        flush;
  logic [2:0]  wr_op;
  logic [1:0]  wr_ac;
  logic [1:0]  rd_ac;
  logic [31:0] wr_hi;
  logic [31:0] wr_lo;
  logic [31:0] rd_hi_v [NI];
  logic [31:0] rd_lo_v [NI];
  logic        pend_v  [NI];

  int total;
  int bad;

  longint unsigned m_acc [NI][4];
  bit              m_pv  [NI];
  int              m_op;
  int              m_ac;
  longint unsigned m_opd;

  hilo_acc_bank #(.DATA_W(32), .NUM_AC(4)) u_dut4 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_op(wr_op), .wr_ac(wr_ac),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .flush(flush), .rd_ac(rd_ac),
    .rd_hi(rd_hi_v[0]), .rd_lo(rd_lo_v[0]), .pend(pend_v[0])
  );

  hilo_acc_bank #(.DATA_W(32), .NUM_AC(3)) u_dut3 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_op(wr_op), .wr_ac(wr_ac),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .flush(flush), .rd_ac(rd_ac),
    .rd_hi(rd_hi_v[1]), .rd_lo(rd_lo_v[1]), .pend(pend_v[1])
  );

  hilo_acc_bank #(.DATA_W(32), .NUM_AC(1), .AC_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_op(wr_op), .wr_ac(wr_ac),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .flush(flush), .rd_ac(rd_ac),
    .rd_hi(rd_hi_v[2]), .rd_lo(rd_lo_v[2]), .pend(pend_v[2])
  );

  always #5 clk = ~clk;

  function automatic int num_of(input int k);
    case (k)
      0:       return 4;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic longint unsigned apply(input int op, input longint unsigned old,
                                            input longint unsigned opd);
    case (op)
      1:       return {opd[63:32], old[31:0]};
      2:       return {old[63:32], opd[31:0]};
      3:       return opd;
      4:       return old + opd;
      5:       return old - opd;
      6:       return 64'd0;
      default: return old;
    endcase
  endfunction

  function automatic longint unsigned model_rd(input int k, input int ac);
    if (ac >= num_of(k)) return 64'd0;
    if (m_pv[k] && m_ac == ac) return apply(m_op, m_acc[k][ac], m_opd);
    return m_acc[k][ac];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_pv[k] = 1'b0;
      for (int a = 0; a < 4; a++) m_acc[k][a] = 64'd0;
    end
  endtask

  task automatic model_edge(input bit v, input int op, input int ac,
                            input longint unsigned opd, input bit fl);
    for (int k = 0; k < NI; k++) begin
      if (m_pv[k] && !fl) m_acc[k][m_ac] = apply(m_op, m_acc[k][m_ac], m_opd);
      m_pv[k] = v && !fl && op >= 1 && op <= 6 && ac < num_of(k);
    end
    m_op  = op;
    m_ac  = ac;
    m_opd = opd;
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic check_rd(input string tag, input int k, input int ac, input logic [63:0] exp);
    rd_ac = 2'(ac);
    #1;
    check_val(tag, {rd_hi_v[k], rd_lo_v[k]}, exp);
  endtask

  task automatic check_all();
    for (int r = 0; r < 4; r++) begin
      rd_ac = 2'(r);
      #1;
      for (int k = 0; k < NI; k++)
        check_val($sformatf("model_rd n%0d ac%0d", num_of(k), r),
                  {rd_hi_v[k], rd_lo_v[k]}, model_rd(k, r));
    end
    for (int k = 0; k < NI; k++)
      check_val($sformatf("model_pend n%0d", num_of(k)), 64'(pend_v[k]), 64'(m_pv[k]));
  endtask

  task automatic check_zero(input string tag);
    for (int r = 0; r < 4; r++) begin
      rd_ac = 2'(r);
      #1;
      for (int k = 0; k < NI; k++)
        check_val($sformatf("%s rd n%0d ac%0d", tag, num_of(k), r),
                  {rd_hi_v[k], rd_lo_v[k]}, 64'd0);
    end
    for (int k = 0; k < NI; k++)
      check_val($sformatf("%s pend n%0d", tag, num_of(k)), 64'(pend_v[k]), 64'd0);
  endtask

  task automatic step(input bit v, input int op, input int ac,
                      input longint unsigned opd, input bit fl);
    wr_valid = v;
    wr_op    = 3'(op);
    wr_ac    = 2'(ac);
    wr_hi    = opd[63:32];
    wr_lo    = opd[31:0];
    flush    = fl;
    @(posedge clk);
    model_edge(v, op, ac, opd, fl);
    #1;
    check_all();
  endtask

  task automatic do_async_reset();
    rst      = 1'b0;
    wr_valid = 1'b0;
    flush    = 1'b0;
    model_reset();
    check_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_all();
  endtask

  initial begin
    longint unsigned opd;
    int              op;
    int              ac;
    bit              v;
    bit              fl;

    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst   = 1'b0;
    wr_valid = 1'b0;
    flush = 1'b0;
    wr_op = 3'd0;
    wr_ac = 2'd0;
    wr_hi = 32'd0;
    wr_lo = 32'd0;
    rd_ac = 2'd0;
    model_reset();

    check_zero("rst_hold");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_zero("rst_release");

    step(1, 3, 1, 64'h12345678_9ABCDEF0, 0);
    step(1, 1, 1, 64'hFFFFFFFF_0BADF00D, 0);
    step(0, 0, 0, 64'd0, 0);
    check_rd("wr_hi ac1", 0, 1, 64'hFFFFFFFF_9ABCDEF0);
    check_rd("wr ac0 untouched", 0, 0, 64'd0);
    check_rd("wr ac2 untouched", 0, 2, 64'd0);
    check_rd("wr ac3 untouched", 0, 3, 64'd0);

    step(1, 3, 2, 64'hFFFFFFFF_FFFFFFFF, 0);
    step(1, 4, 2, 64'd1, 0);
    step(0, 0, 0, 64'd0, 0);
    check_rd("madd wrap", 0, 2, 64'd0);
    step(1, 5, 2, 64'd1, 0);
    step(0, 0, 0, 64'd0, 0);
    check_rd("msub wrap", 0, 2, 64'hFFFFFFFF_FFFFFFFF);

    step(1, 4, 3, 64'd5, 0);
    check_rd("b2b first", 0, 3, 64'd5);
    step(1, 4, 3, 64'd5, 0);
    check_rd("b2b second", 0, 3, 64'd10);
    step(1, 4, 3, 64'd5, 0);
    check_rd("b2b third", 0, 3, 64'd15);
    step(0, 0, 0, 64'd0, 0);
    check_rd("b2b settled", 0, 3, 64'd15);
    step(0, 0, 0, 64'd0, 0);
    check_rd("b2b stable", 0, 3, 64'd15);

    step(1, 4, 0, 64'd7, 0);
    step(1, 2, 0, 64'd9, 1);
    check_rd("flush ac0", 0, 0, 64'd0);
    check_val("flush pend", 64'(pend_v[0]), 64'd0);
    step(0, 0, 0, 64'd0, 0);
    check_rd("flush ac0 later", 0, 0, 64'd0);

    step(1, 3, 3, 64'hCAFEF00D_DEADBEEF, 0);
    step(0, 0, 0, 64'd0, 0);
    check_rd("n4 ac3 written", 0, 3, 64'hCAFEF00D_DEADBEEF);
    check_rd("n3 ac3 dropped", 1, 3, 64'd0);
    check_rd("n1 ac3 dropped", 2, 3, 64'd0);
    check_rd("n1 ac0 unaffected", 2, 0, 64'd0);

    step(1, 3, 1, 64'h11112222_33334444, 0);
    do_async_reset();

    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 9) < 8);
      op = int'($urandom_range(0, 7));
      ac = int'($urandom_range(0, 3));
      fl = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       opd = 64'($urandom_range(0, 15));
        1:       opd = 64'hFFFFFFFF_FFFFFFFF;
        2:       opd = {32'($urandom), 32'($urandom)};
        default: opd = 64'd1 << $urandom_range(0, 63);
      endcase
      step(v, op, ac, opd, fl);
      if ($urandom_range(0, 99) == 0) do_async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
